// File: rtl/load_unit.sv
// Load unit for RV32/RV64: decodes one load micro-op, checks funct3 and
// alignment, runs a req/gnt/rvalid read on the data bus and returns the
// lane-extracted, sign/zero-extended result or an exception.
module load_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] base,
  input  logic [11:0]       imm,
  input  logic [4:0]        rd,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr
);

  localparam int LANE_W = $clog2(XLEN/8);
  localparam int CNT_W  = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_EXC} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ea_in, ea_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  cnt;
  logic              drop;
  logic [XLEN-1:0]   wb_data_q;
  logic [XLEN-1:0]   field, mask, ext;
  logic [6:0]        nbits;
  logic              sgn_bit;
  logic              accept, illegal, misaligned, timeout, busy;

  assign ea_in  = base + {{(ADDR_W-12){imm[11]}}, imm};
  assign accept = (state == S_IDLE) && !drop && op_valid;
  assign busy   = (state == S_REQ) || (state == S_WAIT);
  // An rvalid landing on the last allowed cycle still wins over the timeout.
  assign timeout = busy && (cnt == CNT_W'(TIMEOUT-1)) &&
                   !((state == S_WAIT) && mem_rvalid);

  // funct3 legality; the 64-bit-only encodings depend on XLEN
  always_comb begin
    illegal = 1'b1;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      3'b011, 3'b110:                         illegal = (XLEN != 64);
      default:                                illegal = 1'b1;
    endcase
  end

  // natural alignment for the access size encoded in funct3[1:0]
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = ea_in[0];
      2'b10:   misaligned = |ea_in[1:0];
      2'b11:   misaligned = |ea_in[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // lane extraction and extension; mask covers the access width, its top bit is the sign
  always_comb begin
    field   = mem_rdata >> {ea_q[LANE_W-1:0], 3'b000};
    nbits   = 7'd8 << f3_q[1:0];
    mask    = ~({XLEN{1'b1}} << nbits);
    sgn_bit = |(field & mask & ~(mask >> 1));
    ext     = (!f3_q[2] && sgn_bit) ? (field | ~mask) : (field & mask);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state: flush beats timeout, timeout beats grant
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (illegal || misaligned) ? S_EXC : S_REQ;
      S_REQ: begin
        if (flush)        state_n = S_IDLE;
        else if (timeout) state_n = S_EXC;
        else if (mem_gnt) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (flush)           state_n = S_IDLE;
        else if (mem_rvalid) state_n = S_RESP;
        else if (timeout)    state_n = S_EXC;
      end
      S_RESP:  state_n = S_IDLE;
      S_EXC:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    op_ready  = (state == S_IDLE) && !drop;
    mem_req   = (state == S_REQ);
    wb_valid  = (state == S_RESP);
    exc_valid = (state == S_EXC);
  end

  assign mem_addr  = {ea_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign exc_addr  = ea_q;
  assign exc_cause = cause_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;

  // op latch, timeout counter, exception cause and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q      <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      cause_q   <= '0;
      cnt       <= '0;
      wb_data_q <= '0;
    end else begin
      if (accept) begin
        ea_q <= ea_in;
        f3_q <= funct3;
        rd_q <= rd;
        cnt  <= '0;
        if (illegal || misaligned) cause_q <= illegal ? 2'b10 : 2'b01;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout && !flush) cause_q <= 2'b11;
      if ((state == S_WAIT) && mem_rvalid && !flush) wb_data_q <= ext;
    end
  end

  // drop flag: an access was granted but its response must be swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop <= 1'b0;
    else if ((state == S_REQ) && mem_gnt && (flush || timeout)) drop <= 1'b1;
    else if ((state == S_WAIT) && flush && !mem_rvalid)         drop <= 1'b1;
    else if ((state == S_WAIT) && !flush && timeout)            drop <= 1'b1;
    else if (drop && mem_rvalid)                                drop <= 1'b0;
  end

endmodule
